// File: rtl/or_bist_if.sv
// Status/stimulus bundle between the OR-gate self-test controller and its environment.
// master = controller side, slave = gate-under-test / status-register side.
interface or_bist_if #(
    parameter int ERR_W = 8
);
    logic             START;
    logic             LOOP;
    logic             C;
    logic             A;
    logic             B;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [ERR_W-1:0] ERR_COUNT;
    logic [3:0]       FAIL_VEC;

    modport master (
        input  START, LOOP, C,
        output A, B, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC
    );

    modport slave (
        output START, LOOP, C,
        input  A, B, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC
    );
endinterface

// File: rtl/or_bist.sv
// Self-test controller for a two-input OR gate: walks {A,B} through 00,01,10,11,
// lets each vector settle, samples C and accumulates mismatch statistics.
module or_bist #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    or_bist_if.master    bus
);

    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fail_vec;

    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;
    logic [3:0]       w_fail_next;
    logic [1:0]       w_idx_next;

    // The vector index doubles as the stimulus, so A/B are pure register outputs.
    assign bus.A         = r_idx[1];
    assign bus.B         = r_idx[0];
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.PASS      = r_pass;
    assign bus.ERR_COUNT = r_err;
    assign bus.FAIL_VEC  = r_fail_vec;

    // NOTE: continuous assigns cover every bit unconditionally, so no latch can form here.
    assign w_mismatch  = bus.C != (r_idx[1] | r_idx[0]);
    assign w_err_next  = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;
    assign w_fail_next = r_fail_vec | (4'(w_mismatch) << r_idx);
    assign w_idx_next  = r_idx + 2'd1;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_fail_vec <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.START) begin
                        r_err      <= '0;
                        r_fail_vec <= '0;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_err      <= w_err_next;
                    r_fail_vec <= w_fail_next;
                    // Index 3 wraps to 0 on its own, which is exactly the LOOP behaviour.
                    if ((r_idx != 2'd3) || bus.LOOP) begin
                        r_idx   <= w_idx_next;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/or_bist.md
# or_bist

Synthesizable self-test controller for the two-input OR gate: the hardware counterpart of the bench stimulus. It drives all four A/B input combinations into the gate under test and waits a programmable settle time. It then samples the gate's C output and checks it against A|B. Error count, per-vector fail flags and a pass/fail verdict are reported for board-level LEDs or a status register.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles each vector is held before C is sampled. The legal minimum is 1; 0 is illegal.
- ERR_W, default 8: width of ERR_COUNT. The minimum is 2.

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  run request, sampled only in IDLE.
- LOOP  in  1  continuous mode, sampled at the last SAMPLE of each pass.
- C  in  1  output of the gate under test.
- A  out  1  stimulus to the gate, registered.
- B  out  1  stimulus to the gate, registered.
- BUSY  out  1  a run is in progress.
- DONE  out  1  results valid. Held until the next accepted START or reset.
- PASS  out  1  no mismatch in the run. Meaningful only while DONE=1.
- ERR_COUNT  out  ERR_W  mismatches in the run. Saturating.
- FAIL_VEC  out  4  sticky per-vector mismatch flags. Bit i = vector i.

## Operation
- Vector index i runs 0..3, with A=i[1] and B=i[0]. The order is therefore {A,B} = 00, 01, 10, 11. Expected C for vector i is A|B, i.e. 0,1,1,1.
- States: IDLE, SETTLE, SAMPLE.
- IDLE with START=1:
  - Clear ERR_COUNT, FAIL_VEC and DONE.
  - Set BUSY=1 and i=0, drive {A,B}=00.
  - Load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: decrement the counter each cycle. When the counter is 0, go to SAMPLE. C is ignored in this state, so glitches here never count.
- SAMPLE: compare C with A|B. On a mismatch:
  - ERR_COUNT increments, saturating at 2^ERR_W-1.
  - FAIL_VEC[i] is set.
- SAMPLE with i<3: increment i, drive the next vector, reload the counter and go to SETTLE.
- SAMPLE with i=3 and LOOP=1:
  - Wrap i to 0 and drive 00; return to SETTLE.
  - ERR_COUNT and FAIL_VEC keep accumulating, and BUSY stays high.
- SAMPLE with i=3 and LOOP=0:
  - Go to IDLE with BUSY=0 and DONE=1.
  - PASS=1 if and only if ERR_COUNT (including this sample's update) is 0.
  - A and B hold vector 11.
- START is ignored while BUSY=1. It is level-sensitive in IDLE, so a held START re-arms a new run the cycle after DONE rises.
- LOOP changes mid-pass have no effect until the pass's final SAMPLE.

## Timing
- Reset values: A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FAIL_VEC=0; state IDLE, i=0.
- Reset is asserted asynchronously at any point, including mid-run, and takes effect immediately. Release is synchronous to CLK, and there is no partial result.
- Edge e0 is the edge at which START is sampled.
  - The new vector appears on A/B after e0, and BUSY rises after e0.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
- C for vector k is sampled at edge e0+(k+1)(SETTLE_CYCLES+1). The next vector is driven from that same edge.
- DONE, PASS and the final ERR_COUNT/FAIL_VEC appear after edge e0+4(SETTLE_CYCLES+1). With the default, that is 20 cycles after START is sampled.
- A and B are register outputs with no combinational path from any input. C has a single-cycle sample path only.

## Test plan
- Good gate (C=A|B), SETTLE_CYCLES=4, one-cycle START:
  - A/B step 00, 01, 10, 11, each held 5 cycles.
  - DONE rises 20 cycles after the START edge, with PASS=1, ERR_COUNT=0, FAIL_VEC=0000.
- C stuck at 0 -> ERR_COUNT=3, FAIL_VEC=1110, PASS=0. C stuck at 1 -> ERR_COUNT=1, FAIL_VEC=0001, PASS=0.
- ERR_W=2, C stuck at 0, LOOP held high for 3 passes, then dropped:
  - ERR_COUNT saturates at 3 and never wraps, and FAIL_VEC=1110.
  - DONE rises only at the end of the pass in which LOOP was low at the final SAMPLE.
- START pulsed again at cycle 8 of a run -> ignored, and the DONE timing is unchanged. RST_N low at cycle 7 mid-run:
  - All outputs go to reset values immediately.
  - The next START produces a clean 20-cycle run.
- Good gate, but C forced wrong for the first 3 cycles of every SETTLE and correct at each SAMPLE -> PASS=1, ERR_COUNT=0.
- SETTLE_CYCLES=1 with a good gate -> each vector is held 2 cycles, DONE arrives 8 cycles after START, PASS=1.
